// File: rtl/wb_control.sv
// Write-back controller: captures finished PE accumulators into a staging tile and
// drains it row-major into C memory. Optional ReLU on write data: define WB_RELU_EN.
module wb_control #(
    parameter int unsigned N1           = 4,
    parameter int unsigned N2           = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MATRIXSIZE_W = 16,
    parameter int unsigned ADDR_W_C     = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MATRIXSIZE_W-1:0]     M3,
    input  logic [MATRIXSIZE_W-1:0]     M3dN2,
    input  logic [MATRIXSIZE_W-1:0]     M1xM3dN1xN2,
    input  logic [N1*N2-1:0]            init,
    input  logic                        flush,
    input  logic [N1*N2*DATA_W-1:0]     pe_result,
    input  logic                        wr_ready,
    output logic                        wr_en,
    output logic [ADDR_W_C-1:0]         wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int unsigned NPE = N1 * N2;
    localparam int unsigned EW  = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int unsigned AW  = MATRIXSIZE_W + ADDR_W_C;

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StFinish} state_t;

    state_t                  r_state;
    logic [NPE-1:0]          r_cap;
    logic                    r_first_wave;
    logic [DATA_W-1:0]       r_stage [NPE];
    logic [EW-1:0]           r_e;
    logic [MATRIXSIZE_W-1:0] r_tile_c;
    logic [MATRIXSIZE_W-1:0] r_tile_r;
    logic [MATRIXSIZE_W-1:0] r_tile_cntr;

    logic                    w_active;
    logic [NPE-1:0]          w_req;
    logic [NPE-1:0]          w_take;
    logic [NPE-1:0]          w_drop;
    logic [NPE-1:0]          w_rel;
    logic [NPE-1:0]          w_cap_next;
    logic [DATA_W-1:0]       w_stage_next [NPE];
    logic                    w_accept;
    logic                    w_last;
    logic [EW-1:0]           w_e_sel;
    logic [AW-1:0]           w_addr_full;
    logic [DATA_W-1:0]       w_data_sel;
    logic [MATRIXSIZE_W-1:0] w_cntr_inc;

    function automatic logic [DATA_W-1:0] f_out(input logic [DATA_W-1:0] v);
`ifdef WB_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        w_active = (r_state == StCollect) || (r_state == StDrain);
        w_req    = '0;
        if (w_active) begin
            if (flush) begin
                w_req = '1;
            end else if (!((r_state == StCollect) && r_first_wave)) begin
                w_req = init;
            end
        end
        // A slot still holding undrained data refuses new captures.
        w_take   = w_req & ~r_cap;
        w_drop   = w_req & r_cap;
        w_accept = (r_state == StDrain) && wr_en && wr_ready;
        w_last   = (r_e == EW'(NPE - 1));
        w_rel    = '0;
        if (w_accept) begin
            w_rel[r_e] = 1'b1;
        end
        w_cap_next = (r_cap & ~w_rel) | w_take;
        for (int k = 0; k < NPE; k++) begin
            w_stage_next[k] = w_take[k] ? pe_result[k*DATA_W +: DATA_W] : r_stage[k];
        end
        w_e_sel     = (r_state == StDrain) ? r_e + EW'(1) : '0;
        w_addr_full = (AW'(r_tile_r) * AW'(N1) + AW'(w_e_sel / N2)) * AW'(M3)
                      + AW'(r_tile_c) * AW'(N2) + AW'(w_e_sel % N2);
        w_data_sel  = f_out(w_stage_next[w_e_sel]);
        w_cntr_inc  = r_tile_cntr + MATRIXSIZE_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_cap        <= '0;
            r_first_wave <= 1'b1;
            r_e          <= '0;
            r_tile_c     <= '0;
            r_tile_r     <= '0;
            r_tile_cntr  <= '0;
            for (int k = 0; k < NPE; k++) begin
                r_stage[k] <= '0;
            end
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            for (int k = 0; k < NPE; k++) begin
                r_stage[k] <= w_stage_next[k];
            end
            r_cap <= w_cap_next;
            if (|w_drop) begin
                overflow <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    wr_en <= 1'b0;
                    if (start) begin
                        r_state      <= StCollect;
                        r_cap        <= '0;
                        r_first_wave <= 1'b1;
                        r_e          <= '0;
                        r_tile_c     <= '0;
                        r_tile_r     <= '0;
                        r_tile_cntr  <= '0;
                        overflow     <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                StCollect: begin
                    if (r_first_wave && (init[NPE-1] || flush)) begin
                        r_first_wave <= 1'b0;
                    end
                    if (&w_cap_next) begin
                        r_state <= StDrain;
                        r_e     <= '0;
                        wr_en   <= 1'b1;
                        wr_addr <= ADDR_W_C'(w_addr_full);
                        wr_data <= w_data_sel;
                    end
                end
                StDrain: begin
                    if (w_accept) begin
                        if (w_last) begin
                            wr_en       <= 1'b0;
                            r_tile_cntr <= w_cntr_inc;
                            if (r_tile_c == M3dN2 - MATRIXSIZE_W'(1)) begin
                                r_tile_c <= '0;
                                r_tile_r <= r_tile_r + MATRIXSIZE_W'(1);
                            end else begin
                                r_tile_c <= r_tile_c + MATRIXSIZE_W'(1);
                            end
                            if (w_cntr_inc == M1xM3dN1xN2) begin
                                r_state <= StFinish;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= StCollect;
                            end
                        end else begin
                            r_e     <= r_e + EW'(1);
                            wr_addr <= ADDR_W_C'(w_addr_full);
                            wr_data <= w_data_sel;
                        end
                    end
                end
                StFinish: begin
                    r_state <= StIdle;
                    busy    <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
